// File: rtl/regfile_onehot_32_if.sv
// Bus bundle between the write-select demux / read consumers / dump consumer
// and the register file; the register file sits on the slave side.
interface regfile_onehot_32_if #(
    parameter int WIDTH = 32
);
    logic [31:0]      WrEn;
    logic [WIDTH-1:0] WrData;
    logic [4:0]       RdSel1;
    logic [4:0]       RdSel2;
    logic [WIDTH-1:0] RdData1;
    logic [WIDTH-1:0] RdData2;
    logic             WrErr;
    // Dump handshake: a beat transfers on a rising edge where DumpValid and
    // DumpReady are both high; DumpIdx/DumpData hold while DumpReady is low.
    logic             DumpStart;
    logic             DumpReady;
    logic             DumpBusy;
    logic             DumpValid;
    logic [4:0]       DumpIdx;
    logic [WIDTH-1:0] DumpData;
    logic             DumpState;

    modport master (
        output WrEn, WrData, RdSel1, RdSel2, DumpStart, DumpReady,
        input  RdData1, RdData2, WrErr, DumpBusy, DumpValid, DumpIdx, DumpData, DumpState
    );

    modport slave (
        input  WrEn, WrData, RdSel1, RdSel2, DumpStart, DumpReady,
        output RdData1, RdData2, WrErr, DumpBusy, DumpValid, DumpIdx, DumpData, DumpState
    );
endinterface

// File: rtl/regfile_onehot_32.sv
// 32 x WIDTH register file with one-hot write enables, write-first read bypass,
// sticky multi-write error flag and a handshaked register-dump sequencer.
module regfile_onehot_32 #(
    parameter int WIDTH = 32
) (
    input  logic Clock,
    input  logic Reset_n,
    regfile_onehot_32_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } dump_state_e;

    logic [WIDTH-1:0] regs_q [32];
    logic             wr_nonzero;
    logic             wr_single;
    logic             wr_multi;
    logic             wr_valid;
    logic             err_q, err_d;
    dump_state_e      state_q, state_d;
    logic [4:0]       idx_q, idx_d;
    logic [4:0]       idx_nxt;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] rd1, rd2, cap;

    // Exactly one bit set iff clearing the lowest set bit leaves nothing.
    assign wr_nonzero = |bus.WrEn;
    assign wr_single  = wr_nonzero && ((bus.WrEn & (bus.WrEn - 32'd1)) == 32'd0);
    assign wr_multi   = wr_nonzero && !wr_single;
    assign wr_valid   = wr_single && !bus.WrEn[0];
    assign idx_nxt    = idx_q + 5'd1;
    assign err_d      = err_q | wr_multi;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int k = 0; k < 32; k++) regs_q[k] <= '0;
        end else begin
            for (int k = 1; k < 32; k++) begin
                if (wr_valid && bus.WrEn[k]) regs_q[k] <= bus.WrData;
            end
        end
    end

    // Read ports and the dump capture all see the post-edge register view.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (bus.RdSel1 != 5'd0)
            rd1 = (wr_valid && bus.WrEn[bus.RdSel1]) ? bus.WrData : regs_q[bus.RdSel1];
        if (bus.RdSel2 != 5'd0)
            rd2 = (wr_valid && bus.WrEn[bus.RdSel2]) ? bus.WrData : regs_q[bus.RdSel2];
        cap = (wr_valid && bus.WrEn[idx_nxt]) ? bus.WrData : regs_q[idx_nxt];
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            err_q   <= 1'b0;
            state_q <= IDLE;
            idx_q   <= 5'd0;
            data_q  <= '0;
        end else begin
            err_q   <= err_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (bus.DumpStart) begin
                    state_d = SCAN;
                    idx_d   = 5'd0;
                    data_d  = '0;
                end
            end
            SCAN: begin
                if (bus.DumpReady) begin
                    if (idx_q == 5'd31) begin
                        state_d = IDLE;
                        idx_d   = 5'd0;
                        data_d  = '0;
                    end else begin
                        idx_d  = idx_nxt;
                        data_d = cap;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 5'd0;
                data_d  = '0;
            end
        endcase
    end

    assign bus.RdData1   = rd1;
    assign bus.RdData2   = rd2;
    assign bus.WrErr     = err_q;
    assign bus.DumpValid = (state_q == SCAN);
    assign bus.DumpBusy  = (state_q == SCAN);
    assign bus.DumpIdx   = idx_q;
    assign bus.DumpData  = data_q;
    assign bus.DumpState = state_q;
endmodule

// File: tb/tb_regfile_onehot_32.sv
// Directed plus randomized checks of regfile_onehot_32 against an array-based
// model of the register file and the dump beat sequence.
module tb_regfile_onehot_32;
    logic Clock;
    logic Reset_n;
    int   tests = 0;
    int   fails = 0;

    logic [31:0] m_regs [32];
    logic        m_err;
    logic        m_busy;
    logic [4:0]  m_idx;
    logic [31:0] m_data;

    regfile_onehot_32_if #(.WIDTH(32)) bus ();

    regfile_onehot_32 #(.WIDTH(32)) dut (
        .Clock  (Clock),
        .Reset_n(Reset_n),
        .bus    (bus)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 32; k++) m_regs[k] = '0;
        m_err  = 1'b0;
        m_busy = 1'b0;
        m_idx  = '0;
        m_data = '0;
    endtask

    function automatic logic [31:0] model_rd(input logic [4:0] sel);
        if (sel == 5'd0) return 32'd0;
        if ($countones(bus.WrEn) == 1 && bus.WrEn[sel]) return bus.WrData;
        return m_regs[sel];
    endfunction

    // Applies what the coming rising edge does, from the current inputs.
    task automatic model_step();
        int n;
        n = $countones(bus.WrEn);
        if (n > 1) m_err = 1'b1;
        else if (n == 1 && !bus.WrEn[0]) begin
            for (int k = 1; k < 32; k++) if (bus.WrEn[k]) m_regs[k] = bus.WrData;
        end
        if (!m_busy) begin
            if (bus.DumpStart) begin
                m_busy = 1'b1;
                m_idx  = '0;
                m_data = '0;
            end
        end else if (bus.DumpReady) begin
            if (m_idx == 5'd31) begin
                m_busy = 1'b0;
                m_idx  = '0;
            end else begin
                m_idx  = m_idx + 5'd1;
                m_data = m_regs[m_idx];
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check_all();
        #1;
        check("rd1", bus.RdData1, model_rd(bus.RdSel1));
        check("rd2", bus.RdData2, model_rd(bus.RdSel2));
        check("wr_err", {31'd0, bus.WrErr}, {31'd0, m_err});
        check("dump_valid", {31'd0, bus.DumpValid}, {31'd0, m_busy});
        check("dump_busy", {31'd0, bus.DumpBusy}, {31'd0, m_busy});
        check("dump_idx", {27'd0, bus.DumpIdx}, {27'd0, m_idx});
        if (m_busy) check("dump_data", bus.DumpData, m_data);
    endtask

    task automatic do_reset();
        #2;
        Reset_n = 1'b0;
        model_reset();
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_wren(input bit allow_multi);
        logic [31:0] one;
        int r, a, b;
        one = 32'd1;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'd0;
        if (r == 1) return one;
        if (r == 2 && allow_multi) begin
            a = $urandom_range(0, 31);
            b = (a + $urandom_range(1, 31)) % 32;
            return (one << a) | (one << b);
        end
        return one << $urandom_range(1, 31);
    endfunction

    initial begin
        logic [31:0] one;
        one = 32'd1;
        bus.WrEn = '0;
        bus.WrData = '0;
        bus.RdSel1 = '0;
        bus.RdSel2 = '0;
        bus.DumpStart = 1'b0;
        bus.DumpReady = 1'b0;
        Reset_n = 1'b0;
        model_reset();
        #12;
        check_all();
        check("rst_data", bus.DumpData, 32'd0);
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;

        // Basic write then read back.
        bus.WrEn = 32'h0000_0020;
        bus.WrData = 32'hDEAD_BEEF;
        bus.RdSel1 = 5'd5;
        bus.RdSel2 = 5'd6;
        check_all();
        cycle();
        bus.WrEn = '0;
        check_all();
        check("t1_rd1", bus.RdData1, 32'hDEAD_BEEF);
        check("t1_rd2", bus.RdData2, 32'd0);
        check("t1_err", {31'd0, bus.WrErr}, 32'd0);

        // x0 write dropped, then multi-bit write flagged.
        bus.WrEn = 32'h0000_0001;
        bus.WrData = 32'hFFFF_FFFF;
        bus.RdSel1 = 5'd0;
        check_all();
        cycle();
        bus.WrEn = '0;
        check_all();
        check("x0_zero", bus.RdData1, 32'd0);
        bus.WrEn = 32'h0000_0300;
        bus.WrData = 32'h0000_1234;
        bus.RdSel1 = 5'd8;
        bus.RdSel2 = 5'd9;
        check_all();
        cycle();
        bus.WrEn = '0;
        check_all();
        check("multi_err", {31'd0, bus.WrErr}, 32'd1);
        check("multi_r8", bus.RdData1, 32'd0);
        cycle();
        check_all();

        // Same-cycle bypass on both ports.
        bus.WrEn = 32'h0000_0008;
        bus.WrData = 32'h11;
        cycle();
        bus.WrData = 32'h22;
        bus.RdSel1 = 5'd3;
        bus.RdSel2 = 5'd3;
        check_all();
        check("byp_pre1", bus.RdData1, 32'h22);
        check("byp_pre2", bus.RdData2, 32'h22);
        cycle();
        bus.WrEn = '0;
        check_all();
        check("byp_post", bus.RdData1, 32'h22);

        // Randomized traffic including dumps.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            bus.WrEn = rand_wren(i > 260);
            bus.WrData = $urandom;
            bus.RdSel1 = 5'($urandom_range(0, 31));
            bus.RdSel2 = ($urandom_range(0, 3) == 0) ? bus.RdSel1 : 5'($urandom_range(0, 31));
            bus.DumpStart = ($urandom_range(0, 7) == 0);
            bus.DumpReady = ($urandom_range(0, 2) != 0);
            check_all();
            cycle();
        end
        bus.WrEn = '0;
        bus.DumpStart = 1'b0;
        bus.DumpReady = 1'b0;

        // Full dump with regs k = k*0x100, ready held high.
        do_reset();
        for (int k = 1; k < 32; k++) begin
            bus.WrEn = one << k;
            bus.WrData = 32'(k * 256);
            cycle();
        end
        bus.WrEn = '0;
        bus.DumpReady = 1'b1;
        bus.DumpStart = 1'b1;
        cycle();
        bus.DumpStart = 1'b0;
        for (int b = 0; b < 32; b++) begin
            check_all();
            check("full_idx", {27'd0, bus.DumpIdx}, 32'(b));
            check("full_data", bus.DumpData, 32'(b * 256));
            check("full_busy", {31'd0, bus.DumpBusy}, 32'd1);
            if (b == 15 || b == 31) bus.DumpStart = 1'b1;
            cycle();
            bus.DumpStart = 1'b0;
        end
        check_all();
        check("full_end_busy", {31'd0, bus.DumpBusy}, 32'd0);
        cycle();
        check("full_idle", {31'd0, bus.DumpValid}, 32'd0);

        // Stall at beat 4 with a write, then write beat 5's register on accept.
        bus.DumpStart = 1'b1;
        cycle();
        bus.DumpStart = 1'b0;
        for (int b = 0; b < 4; b++) cycle();
        check("stall_idx", {27'd0, bus.DumpIdx}, 32'd4);
        bus.DumpReady = 1'b0;
        bus.WrEn = 32'h0000_0010;
        bus.WrData = 32'h0000_AAAA;
        cycle();
        bus.WrEn = '0;
        check_all();
        check("stall_data", bus.DumpData, 32'h400);
        check("stall_idx_hold", {27'd0, bus.DumpIdx}, 32'd4);
        bus.DumpReady = 1'b1;
        bus.WrEn = 32'h0000_0020;
        bus.WrData = 32'h0000_5555;
        cycle();
        bus.WrEn = '0;
        check_all();
        check("accept_idx", {27'd0, bus.DumpIdx}, 32'd5);
        check("accept_data", bus.DumpData, 32'h5555);
        for (int b = 0; b < 5; b++) cycle();
        check("pre_rst_idx", {27'd0, bus.DumpIdx}, 32'd10);

        // Asynchronous reset mid-dump.
        #2;
        Reset_n = 1'b0;
        model_reset();
        #1;
        check("arst_valid", {31'd0, bus.DumpValid}, 32'd0);
        check("arst_busy", {31'd0, bus.DumpBusy}, 32'd0);
        check("arst_idx", {27'd0, bus.DumpIdx}, 32'd0);
        check("arst_data", bus.DumpData, 32'd0);
        for (int s = 1; s < 32; s++) begin
            bus.RdSel1 = 5'(s);
            #1;
            check("arst_reg", bus.RdData1, 32'd0);
        end
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle();
            check_all();
        end
        bus.DumpStart = 1'b1;
        cycle();
        bus.DumpStart = 1'b0;
        check_all();
        check("restart_busy", {31'd0, bus.DumpBusy}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
